// File: rtl/serial_frame_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_deser
// Description : Sync-word framed serial-to-parallel deserializer, MSB first.
//               Optional even-parity bit per data word when the macro
//               SERIAL_FRAME_DESER_PAR_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_deser #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = 8'hA5,
    parameter int               WORDS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             locked,
    output logic             sync_err,
    output logic             par_err
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
`ifdef SERIAL_FRAME_DESER_PAR_CHK_EN
    localparam int c_SR_W = WIDTH;
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(WIDTH);
`else
    // Only WIDTH-1 history bits are ever read when no parity bit follows.
    localparam int c_SR_W = WIDTH - 1;
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(WIDTH - 1);
`endif
    localparam logic [c_CNT_W-1:0] c_SYNC_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_ONE   = c_CNT_W'(1);
    localparam logic [7:0]         c_WORDS     = 8'(WORDS);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [7:0]          r_word_cnt;
    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic                r_locked;
    logic                r_sync_err;

    logic [WIDTH-1:0]    w_nw;
    logic [WIDTH-1:0]    w_word;

    assign w_nw = {r_sr[WIDTH-2:0], din};

`ifdef SERIAL_FRAME_DESER_PAR_CHK_EN
    logic r_par_err;
    logic w_par_bad;
    // On the parity-bit edge the window already holds the complete word.
    assign w_word    = r_sr;
    assign w_par_bad = (^r_sr) ^ din;
    assign par_err   = r_par_err;
`else
    assign w_word  = w_nw;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
`ifdef SERIAL_FRAME_DESER_PAR_CHK_EN
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_sr       <= w_nw[c_SR_W-1:0];
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
`ifdef SERIAL_FRAME_DESER_PAR_CHK_EN
            r_par_err  <= 1'b0;
`endif
            case (r_state)
                ST_HUNT: begin
                    if (w_nw == SYNC) begin
                        r_state    <= ST_DATA;
                        r_locked   <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (r_bit_cnt == c_DATA_LAST) begin
                        r_data     <= w_word;
                        r_valid    <= 1'b1;
`ifdef SERIAL_FRAME_DESER_PAR_CHK_EN
                        r_par_err  <= w_par_bad;
`endif
                        r_bit_cnt  <= '0;
                        r_word_cnt <= r_word_cnt + 8'd1;
                        if (r_word_cnt + 8'd1 == c_WORDS) begin
                            r_state <= ST_CHECK;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    end
                end
                ST_CHECK: begin
                    if (r_bit_cnt == c_SYNC_LAST) begin
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        if (w_nw == SYNC) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_sync_err <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign data     = r_data;
    assign valid    = r_valid;
    assign locked   = r_locked;
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire
